// File: rtl/run_sequencer_if.sv
// Port bundle of the run sequencer: load stream, result stream, DataMem port and core handshake.
// The master modport is the sequencer side. The slave modport is the host, core and memory side.
interface run_sequencer_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          core_start;
  logic          core_ack;
  logic          mem_owner;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;

  modport master (
    input  in_valid, in_data, in_last, core_ack, mem_rd_data, out_ready,
    output in_ready, core_start, mem_owner, mem_addr, mem_wr_en, mem_wr_data,
           out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, in_last, core_ack, mem_rd_data, out_ready,
    input  in_ready, core_start, mem_owner, mem_addr, mem_wr_en, mem_wr_data,
           out_valid, out_data
  );
endinterface

// File: rtl/run_sequencer.sv
// Host-side run controller: loads a program image into data memory, starts the core,
// waits for its ack (or times out), then streams the result window back out.
//
// state   | meaning
// S_IDLE  | core owns memory; waiting for the first load byte
// S_LOAD  | writing accepted bytes at LOAD_BASE + lptr
// S_START | core_start held for START_CYCLES cycles; ack ignored
// S_RUN   | counting cycles until ack or TIMEOUT
// S_DRAIN | streaming RESULT_LEN bytes from RESULT_BASE
// S_DONE  | one-cycle done pulse
module run_sequencer #(
  parameter int          AW           = 8,
  parameter int          LOAD_BASE    = 0,
  parameter int          RESULT_BASE  = 64,
  parameter int          RESULT_LEN   = 32,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  run_sequencer_if.master    bus,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [15:0]        cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LOAD_BASE_A   = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RESULT_BASE_A = AW'(RESULT_BASE);
  localparam logic [AW-1:0] LAST_IDX      = AW'(RESULT_LEN - 1);
  localparam logic [15:0]   START_TC      = 16'(START_CYCLES - 1);

  state_t        state, state_nx;
  logic [AW-1:0] lptr, lptr_nx;
  logic [AW-1:0] dptr, dptr_nx;
  logic [15:0]   scnt, scnt_nx;
  logic [15:0]   ccnt_nx;
  logic          terr_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lptr        <= '0;
      dptr        <= '0;
      scnt        <= '0;
      cycle_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      lptr        <= lptr_nx;
      dptr        <= dptr_nx;
      scnt        <= scnt_nx;
      cycle_count <= ccnt_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    lptr_nx         = lptr;
    dptr_nx         = dptr;
    scnt_nx         = scnt;
    ccnt_nx         = cycle_count;
    terr_nx         = timeout_err;
    bus.in_ready    = 1'b0;
    bus.core_start  = 1'b0;
    bus.mem_owner   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    done            = 1'b0;
    busy            = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nx = S_LOAD;
          lptr_nx  = '0;
        end
      end
      S_LOAD: begin
        bus.in_ready    = 1'b1;
        bus.mem_owner   = 1'b1;
        bus.mem_wr_en   = bus.in_valid;
        bus.mem_addr    = LOAD_BASE_A + lptr;
        bus.mem_wr_data = bus.in_data;
        if (bus.in_valid) begin
          lptr_nx = lptr + 1'b1;
          if (bus.in_last) begin
            state_nx = S_START;
            scnt_nx  = START_TC;
            ccnt_nx  = '0;
            terr_nx  = 1'b0;
          end
        end
      end
      S_START: begin
        bus.core_start = 1'b1;
        if (scnt == '0) state_nx = S_RUN;
        else            scnt_nx  = scnt - 16'd1;
      end
      S_RUN: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (bus.core_ack) begin
          state_nx = S_DRAIN;
          dptr_nx  = '0;
        end else begin
          if (cycle_count != 16'hFFFF) ccnt_nx = cycle_count + 16'd1;
          if (({1'b0, cycle_count} + 17'd1) >= {1'b0, TIMEOUT}) begin
            terr_nx  = 1'b1;
            state_nx = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        bus.mem_owner = 1'b1;
        bus.mem_addr  = RESULT_BASE_A + dptr;
        bus.out_valid = 1'b1;
        bus.out_data  = bus.mem_rd_data;
        if (bus.out_ready) begin
          dptr_nx = dptr + 1'b1;
          if (dptr == LAST_IDX) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances differing only in LOAD_BASE run in lockstep
// against a memory model, and each run is compared with an arithmetic expectation.
module tb_run_sequencer;
  localparam int RLEN   = 4;
  localparam int TMO    = 20;
  localparam int BASE_A = 0;
  localparam int BASE_B = 254;
  localparam int RBASE  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        core_ack = 1'b0;
  logic        out_ready = 1'b0;

  logic        busy_a, done_a, terr_a, busy_b, done_b, terr_b;
  logic [15:0] cc_a, cc_b;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  model_a [256];
  logic [7:0]  model_b [256];
  logic [7:0]  prog [16];

  logic [7:0]  wa_addr[$], wa_data[$], wb_addr[$];
  logic [7:0]  drained_a[$], drained_b[$];
  int          start_a, done_cnt_a, hold_viol;
  logic        stall_a = 1'b0;
  logic [7:0]  hold_data_a, hold_addr_a;

  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  run_sequencer_if #(.AW(8)) bus_a ();
  run_sequencer_if #(.AW(8)) bus_b ();

  assign bus_a.in_valid    = in_valid;
  assign bus_a.in_data     = in_data;
  assign bus_a.in_last     = in_last;
  assign bus_a.core_ack    = core_ack;
  assign bus_a.out_ready   = out_ready;
  assign bus_a.mem_rd_data = mem_a[bus_a.mem_addr];
  assign bus_b.in_valid    = in_valid;
  assign bus_b.in_data     = in_data;
  assign bus_b.in_last     = in_last;
  assign bus_b.core_ack    = core_ack;
  assign bus_b.out_ready   = out_ready;
  assign bus_b.mem_rd_data = mem_b[bus_b.mem_addr];

  run_sequencer #(.AW(8), .LOAD_BASE(BASE_A), .RESULT_BASE(RBASE), .RESULT_LEN(RLEN),
                  .START_CYCLES(2), .TIMEOUT(16'(TMO))) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a), .done(done_a),
    .timeout_err(terr_a), .cycle_count(cc_a));

  run_sequencer #(.AW(8), .LOAD_BASE(BASE_B), .RESULT_BASE(RBASE), .RESULT_LEN(RLEN),
                  .START_CYCLES(2), .TIMEOUT(16'(TMO))) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b), .done(done_b),
    .timeout_err(terr_b), .cycle_count(cc_b));

  // Memory and stream monitors
  always @(posedge clk) begin
    if (bus_a.mem_wr_en) begin
      mem_a[bus_a.mem_addr] = bus_a.mem_wr_data;
      wa_addr.push_back(bus_a.mem_addr);
      wa_data.push_back(bus_a.mem_wr_data);
    end
    if (bus_b.mem_wr_en) begin
      mem_b[bus_b.mem_addr] = bus_b.mem_wr_data;
      wb_addr.push_back(bus_b.mem_addr);
    end
    if (bus_a.core_start) start_a++;
    if (done_a) done_cnt_a++;
    if (bus_a.out_valid && out_ready) drained_a.push_back(bus_a.out_data);
    if (bus_b.out_valid && out_ready) drained_b.push_back(bus_b.out_data);
    if (stall_a && bus_a.out_valid &&
        (bus_a.out_data !== hold_data_a || bus_a.mem_addr !== hold_addr_a)) hold_viol++;
    stall_a     = bus_a.out_valid && !out_ready;
    hold_data_a = bus_a.out_data;
    hold_addr_a = bus_a.mem_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wa_addr.delete(); wa_data.delete(); wb_addr.delete();
    drained_a.delete(); drained_b.delete();
    start_a = 0; done_cnt_a = 0; hold_viol = 0;
  endtask

  task automatic drive_bytes(input int n, input int gaps);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      in_data  = prog[i];
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      while (!bus_a.in_ready && g < 10) begin @(negedge clk); g++; end
      checks++;
      if (g >= 10) begin
        errors++;
        $display("FAIL load_accept byte %0d in_ready got 0 want 1", i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_a[(BASE_A + i) % 256] = prog[i];
      model_b[(BASE_B + i) % 256] = prog[i];
      if (i < n - 1) repeat (gaps) @(negedge clk);
    end
  endtask

  task automatic wait_run();
    int g = 0;
    while (!bus_a.core_start && g < 20) begin @(negedge clk); g++; end
    while (bus_a.core_start && g < 20) begin @(negedge clk); g++; end
    checks++;
    if (g >= 20) begin
      errors++;
      $display("FAIL start_window core_start pulse not seen within %0d cycles", g);
    end
  endtask

  task automatic finish_drain(input int mode);
    int ph = 0;
    int g = 0;
    while (busy_a && g < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      ph++;
      g++;
    end
    out_ready = 1'b0;
    checks++;
    if (g >= 300) begin
      errors++;
      $display("FAIL run_complete busy got 1 want 0 after %0d cycles", g);
    end
  endtask

  // d >= 100 means the ack is never driven
  task automatic run_prog(input int n, input int gaps, input int d, input int mode, input bit stale);
    clear_logs();
    if (stale) core_ack = 1'b1;
    drive_bytes(n, gaps);
    wait_run();
    if (stale) begin
      @(negedge clk);
      core_ack = 1'b0;
    end else if (d < 100) begin
      repeat (d) @(negedge clk);
      core_ack = 1'b1;
      @(negedge clk);
      core_ack = 1'b0;
    end
    finish_drain(mode);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, terr_a, bus_a.in_ready, bus_a.core_start, bus_a.mem_owner,
         bus_a.mem_wr_en, bus_a.out_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000", {busy_a, done_a, terr_a,
               bus_a.in_ready, bus_a.core_start, bus_a.mem_owner, bus_a.mem_wr_en, bus_a.out_valid});
    end
    checks++;
    if (cc_a !== 16'd0 || bus_a.mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts cycle_count %0d addr %0h want 0 0", cc_a, bus_a.mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    prog[0] = 8'hA5; prog[1] = 8'h3C; prog[2] = 8'hFF;
    run_prog(3, 2, 10, 0, 1'b0);
    checks++;
    if (wa_addr.size() != 3) begin
      errors++;
      $display("FAIL load_count writes got %0d want 3", wa_addr.size());
    end
    for (int i = 0; i < 3 && i < wa_addr.size(); i++) begin
      checks++;
      if (wa_addr[i] !== 8'(i) || wa_data[i] !== prog[i]) begin
        errors++;
        $display("FAIL load_write %0d got %0h@%0h want %0h@%0h", i, wa_data[i], wa_addr[i], prog[i], i);
      end
    end
    checks++;
    if (start_a != 2) begin
      errors++;
      $display("FAIL start_cycles got %0d want 2", start_a);
    end
    checks++;
    if (cc_a !== 16'd10 || terr_a !== 1'b0) begin
      errors++;
      $display("FAIL normal_cycles cycle_count %0d terr %b want 10 0", cc_a, terr_a);
    end
    checks++;
    if (drained_a.size() != RLEN || done_cnt_a != 1) begin
      errors++;
      $display("FAIL normal_drain bytes %0d done %0d want %0d 1", drained_a.size(), done_cnt_a, RLEN);
    end
    for (int k = 0; k < RLEN && k < drained_a.size(); k++) begin
      checks++;
      if (drained_a[k] !== model_a[(RBASE + k) % 256]) begin
        errors++;
        $display("FAIL normal_byte %0d got %0h want %0h", k, drained_a[k], model_a[(RBASE + k) % 256]);
      end
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 8);
      int d = $urandom_range(0, TMO - 1);
      for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
      run_prog(n, $urandom_range(0, 2), d, 2, 1'b0);
      checks++;
      if (wa_addr.size() != n || wb_addr.size() != n) begin
        errors++;
        $display("FAIL rand_writes run %0d got %0d/%0d want %0d", r, wa_addr.size(), wb_addr.size(), n);
      end
      for (int i = 0; i < n && i < wa_addr.size() && i < wb_addr.size(); i++) begin
        checks++;
        if (wa_addr[i] !== 8'((BASE_A + i) % 256) || wa_data[i] !== prog[i] ||
            wb_addr[i] !== 8'((BASE_B + i) % 256)) begin
          errors++;
          $display("FAIL rand_write run %0d idx %0d got %0h@%0h/%0h want %0h@%0h/%0h", r, i,
                   wa_data[i], wa_addr[i], wb_addr[i], prog[i], (BASE_A + i) % 256, (BASE_B + i) % 256);
        end
      end
      checks++;
      if (cc_a !== 16'(d) || terr_a !== 1'b0 || done_cnt_a != 1) begin
        errors++;
        $display("FAIL rand_status run %0d cc %0d terr %b done %0d want %0d 0 1", r, cc_a, terr_a, done_cnt_a, d);
      end
      checks++;
      if (drained_a.size() != RLEN || drained_b.size() != RLEN) begin
        errors++;
        $display("FAIL rand_drain_len run %0d got %0d/%0d want %0d", r, drained_a.size(), drained_b.size(), RLEN);
      end
      for (int k = 0; k < RLEN && k < drained_a.size() && k < drained_b.size(); k++) begin
        checks++;
        if (drained_a[k] !== model_a[(RBASE + k) % 256] || drained_b[k] !== model_b[(RBASE + k) % 256]) begin
          errors++;
          $display("FAIL rand_byte run %0d idx %0d got %0h/%0h want %0h/%0h", r, k, drained_a[k],
                   drained_b[k], model_a[(RBASE + k) % 256], model_b[(RBASE + k) % 256]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
    run_prog(3, 0, 3, 1, 1'b0);
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL bp_hold stall changes got %0d want 0", hold_viol);
    end
    checks++;
    if (drained_a.size() != RLEN) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", drained_a.size(), RLEN);
    end
    for (int k = 0; k < RLEN && k < drained_a.size(); k++) begin
      checks++;
      if (drained_a[k] !== model_a[(RBASE + k) % 256]) begin
        errors++;
        $display("FAIL bp_byte %0d got %0h want %0h", k, drained_a[k], model_a[(RBASE + k) % 256]);
      end
    end
  endtask

  task automatic test_timeout();
    prog[0] = 8'h11; prog[1] = 8'h22;
    run_prog(2, 0, 1000, 0, 1'b0);
    checks++;
    if (terr_a !== 1'b1 || cc_a !== 16'(TMO)) begin
      errors++;
      $display("FAIL timeout_status terr %b cc %0d want 1 %0d", terr_a, cc_a, TMO);
    end
    checks++;
    if (drained_a.size() != 0 || done_cnt_a != 1) begin
      errors++;
      $display("FAIL timeout_flow drained %0d done %0d want 0 1", drained_a.size(), done_cnt_a);
    end
    // ack lands in the very cycle the count would reach TIMEOUT
    run_prog(1, 0, TMO - 1, 0, 1'b0);
    checks++;
    if (terr_a !== 1'b0 || cc_a !== 16'(TMO - 1) || drained_a.size() != RLEN) begin
      errors++;
      $display("FAIL ack_wins terr %b cc %0d drained %0d want 0 %0d %0d", terr_a, cc_a,
               drained_a.size(), TMO - 1, RLEN);
    end
  endtask

  task automatic test_stale_ack_wrap();
    for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
    run_prog(4, 1, 0, 0, 1'b1);
    checks++;
    if (start_a != 2 || cc_a !== 16'd0 || drained_a.size() != RLEN) begin
      errors++;
      $display("FAIL stale_ack starts %0d cc %0d drained %0d want 2 0 %0d", start_a, cc_a,
               drained_a.size(), RLEN);
    end
    checks++;
    if (wb_addr.size() != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d want 4", wb_addr.size());
    end
    for (int i = 0; i < 4 && i < wb_addr.size(); i++) begin
      checks++;
      if (wb_addr[i] !== 8'((BASE_B + i) % 256)) begin
        errors++;
        $display("FAIL wrap_addr %0d got %0h want %0h", i, wb_addr[i], (BASE_B + i) % 256);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int bad = 0;
    clear_logs();
    prog[0] = 8'h5A; prog[1] = 8'hC3;
    drive_bytes(2, 0);
    wait_run();
    repeat (5) @(negedge clk);
    core_ack = 1'b1;
    @(negedge clk);
    core_ack = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.out_valid !== 1'b1 || cc_a !== 16'd5) begin
      errors++;
      $display("FAIL pre_reset_drain out_valid %b cc %0d want 1 5", bus_a.out_valid, cc_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, terr_a, bus_a.in_ready, bus_a.core_start, bus_a.mem_owner,
         bus_a.mem_wr_en, bus_a.out_valid} !== 8'h00 || cc_a !== 16'd0 || bus_a.mem_addr !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset outputs %b cc %0d addr %0h want all zero", {busy_a, done_a, terr_a,
               bus_a.in_ready, bus_a.core_start, bus_a.mem_owner, bus_a.mem_wr_en, bus_a.out_valid},
               cc_a, bus_a.mem_addr);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || bus_a.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle busy cycles got %0d want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem_a[i] = v; model_a[i] = v;
      mem_b[i] = v; model_b[i] = v;
    end
    @(negedge clk);
    test_reset();
    test_load();
    test_random_runs();
    test_backpressure();
    test_timeout();
    test_stale_ack_wrap();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
